// File: rtl/node_controller.sv
// Central control FSM of a clustered EER-RL sensor node: decodes the received packet
// type, pulses write enables to the sibling tables and gates transmissions on channel_clear.
module node_controller #(
    parameter int WORD_WIDTH = 16,
    parameter int MAX_HOPS   = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [2:0]            fPacketType,
    input  logic [WORD_WIDTH-1:0] fHopsFromCH,
    input  logic [WORD_WIDTH-1:0] fChosenCH,
    input  logic [WORD_WIDTH-1:0] fTimeslot,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic                  channel_clear,
    input  logic [WORD_WIDTH-1:0] myTimeslot,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic                  role,
    input  logic                  iHaveData,
    input  logic [WORD_WIDTH-1:0] chosenCH,
    output logic                  en_KCH,
    output logic                  en_MNI,
    output logic                  en_QTU_FMB,
    output logic                  en_neighborTable,
    output logic                  en_reward,
    output logic                  iAmDestination,
    output logic                  okToSend
);

    localparam logic [WORD_WIDTH-1:0] MAX_HOPS_W   = WORD_WIDTH'(MAX_HOPS);
    localparam logic [WORD_WIDTH-1:0] NO_TIMESLOT  = '1;

    typedef enum logic [3:0] {
        IDLE,
        P_HB,
        P_CHE,
        P_INV,
        P_MR,
        P_CHT,
        P_DATA,
        P_SOS,
        WAIT_CLEAR,
        SEND
    } state_t;

    state_t state;
    state_t state_next;

    logic dest_match;
    logic hops_ok;
    logic have_slot;

    // The CH timeslot is latched by myNodeInfo directly; this block never looks at it.
    logic unused_timeslot;
    assign unused_timeslot = ^fTimeslot;

    assign dest_match = (destinationID == myNodeID);
    assign hops_ok    = (fHopsFromCH < MAX_HOPS_W);
    assign have_slot  = (myTimeslot != NO_TIMESLOT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = IDLE;
        en_KCH           = 1'b0;
        en_MNI           = 1'b0;
        en_QTU_FMB       = 1'b0;
        en_neighborTable = 1'b0;
        en_reward        = 1'b0;
        iAmDestination   = 1'b0;
        okToSend         = 1'b0;

        unique case (state)
            IDLE: begin
                // A received packet always wins over pending own data.
                unique case (fPacketType)
                    3'b000: state_next = P_HB;
                    3'b001: state_next = P_CHE;
                    3'b010: state_next = P_INV;
                    3'b011: state_next = P_MR;
                    3'b100: state_next = P_CHT;
                    3'b101: state_next = P_DATA;
                    3'b110: state_next = P_SOS;
                    default: state_next = (iHaveData && have_slot) ? WAIT_CLEAR : IDLE;
                endcase
            end
            P_HB: begin
                en_MNI           = 1'b1;
                en_neighborTable = 1'b1;
                state_next       = WAIT_CLEAR;
            end
            P_CHE: begin
                en_MNI = 1'b1;
            end
            P_INV: begin
                en_KCH     = 1'b1;
                state_next = (!role && hops_ok) ? WAIT_CLEAR : IDLE;
            end
            P_MR: begin
                en_neighborTable = (fChosenCH == chosenCH);
            end
            P_CHT: begin
                en_MNI         = dest_match;
                iAmDestination = dest_match;
            end
            P_DATA: begin
                iAmDestination = dest_match;
                en_QTU_FMB     = dest_match;
                en_reward      = dest_match;
                // Members forward data addressed to them on toward their CH.
                state_next     = (dest_match && !role) ? WAIT_CLEAR : IDLE;
            end
            P_SOS: begin
                en_KCH     = 1'b1;
                en_QTU_FMB = 1'b1;
            end
            WAIT_CLEAR: begin
                state_next = channel_clear ? SEND : WAIT_CLEAR;
            end
            SEND: begin
                okToSend = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_node_controller.sv
// Directed, table-driven bench for node_controller: one table row per clock cycle,
// plus hand-written sequences for reset during a pending transmission.
module tb_node_controller;

    logic        clk;
    logic        nrst;
    logic [2:0]  fPacketType;
    logic [15:0] fHopsFromCH;
    logic [15:0] fChosenCH;
    logic [15:0] fTimeslot;
    logic [15:0] destinationID;
    logic        channel_clear;
    logic [15:0] myTimeslot;
    logic [15:0] myNodeID;
    logic        role;
    logic        iHaveData;
    logic [15:0] chosenCH;
    logic        en_KCH;
    logic        en_MNI;
    logic        en_QTU_FMB;
    logic        en_neighborTable;
    logic        en_reward;
    logic        iAmDestination;
    logic        okToSend;

    int n_checks;
    int n_pass;

    // Output vector order: {KCH, MNI, QTU_FMB, NT, REWARD, IAMDEST, OK}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_KCH  = 7'b1000000;
    localparam logic [6:0] O_MNI  = 7'b0100000;
    localparam logic [6:0] O_QTU  = 7'b0010000;
    localparam logic [6:0] O_NT   = 7'b0001000;
    localparam logic [6:0] O_RW   = 7'b0000100;
    localparam logic [6:0] O_DST  = 7'b0000010;
    localparam logic [6:0] O_OK   = 7'b0000001;

    typedef struct {
        string       name;
        logic [2:0]  pt;
        logic [15:0] hops;
        logic [15:0] fch;
        logic [15:0] dest;
        logic [15:0] myts;
        logic        clear;
        logic        role;
        logic        data;
        logic [6:0]  exp;
    } vec_t;

    vec_t vecs[$];

    node_controller #(.WORD_WIDTH(16), .MAX_HOPS(4)) dut (
        .clk              (clk),
        .nrst             (nrst),
        .fPacketType      (fPacketType),
        .fHopsFromCH      (fHopsFromCH),
        .fChosenCH        (fChosenCH),
        .fTimeslot        (fTimeslot),
        .destinationID    (destinationID),
        .channel_clear    (channel_clear),
        .myTimeslot       (myTimeslot),
        .myNodeID         (myNodeID),
        .role             (role),
        .iHaveData        (iHaveData),
        .chosenCH         (chosenCH),
        .en_KCH           (en_KCH),
        .en_MNI           (en_MNI),
        .en_QTU_FMB       (en_QTU_FMB),
        .en_neighborTable (en_neighborTable),
        .en_reward        (en_reward),
        .iAmDestination   (iAmDestination),
        .okToSend         (okToSend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic [2:0] pt, logic [15:0] hops, logic [15:0] fch,
                                logic [15:0] dest, logic [15:0] myts, logic clear, logic rl,
                                logic data, logic [6:0] exp);
        vec_t v;
        v.name  = name;
        v.pt    = pt;
        v.hops  = hops;
        v.fch   = fch;
        v.dest  = dest;
        v.myts  = myts;
        v.clear = clear;
        v.role  = rl;
        v.data  = data;
        v.exp   = exp;
        return v;
    endfunction

    function automatic logic [6:0] outs();
        return {en_KCH, en_MNI, en_QTU_FMB, en_neighborTable, en_reward, iAmDestination, okToSend};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: outputs got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        fPacketType   = v.pt;
        fHopsFromCH   = v.hops;
        fChosenCH     = v.fch;
        destinationID = v.dest;
        myTimeslot    = v.myts;
        channel_clear = v.clear;
        role          = v.role;
        iHaveData     = v.data;
    endtask

    // Drive one cycle of idle-looking inputs with the given own-data controls.
    task automatic drive_idle(input logic clear, input logic data, input logic [15:0] myts);
        apply(mk("", 3'b111, 16'd0, 16'd0, 16'd0, myts, clear, 1'b0, data, O_NONE));
    endtask

    initial begin
        logic [15:0] NS;
        NS = 16'hffff;
        n_checks = 0;
        n_pass   = 0;

        // Each row: inputs held for one cycle, expected outputs during that cycle.
        vecs.push_back(mk("idle_after_rst", 3'b111, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("hb_dispatch",    3'b000, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("hb_enables",     3'b111, 0, 0, 0, NS, 0, 0, 0, O_MNI | O_NT));
        vecs.push_back(mk("hb_wait1",       3'b111, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("hb_wait2",       3'b111, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("hb_wait_clear",  3'b111, 0, 0, 0, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("hb_send",        3'b111, 0, 0, 0, NS, 1, 0, 0, O_OK));
        vecs.push_back(mk("hb_back_idle",   3'b111, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("inv1_dispatch",  3'b010, 1, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("inv1_kch",       3'b111, 1, 0, 0, NS, 0, 0, 0, O_KCH));
        vecs.push_back(mk("inv1_wait",      3'b111, 1, 0, 0, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("inv1_send",      3'b111, 1, 0, 0, NS, 1, 0, 0, O_OK));
        vecs.push_back(mk("inv4_dispatch",  3'b010, 4, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("inv4_kch",       3'b111, 4, 0, 0, NS, 1, 0, 0, O_KCH));
        vecs.push_back(mk("inv4_no_send1",  3'b111, 4, 0, 0, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("inv4_no_send2",  3'b111, 4, 0, 0, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("inv3_dispatch",  3'b010, 3, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("inv3_kch",       3'b111, 3, 0, 0, NS, 1, 0, 0, O_KCH));
        vecs.push_back(mk("inv3_wait",      3'b111, 3, 0, 0, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("inv3_send",      3'b111, 3, 0, 0, NS, 0, 0, 0, O_OK));
        vecs.push_back(mk("mr35_dispatch",  3'b011, 0, 35, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("mr35_no_nt",     3'b111, 0, 35, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("mr23_dispatch",  3'b011, 0, 23, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("mr23_nt_a",      3'b011, 0, 23, 0, NS, 0, 0, 0, O_NT));
        vecs.push_back(mk("mr23_redisp",    3'b011, 0, 23, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("mr23_nt_b",      3'b111, 0, 23, 0, NS, 0, 0, 0, O_NT));
        vecs.push_back(mk("mr_idle",        3'b111, 0, 23, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("cht3_dispatch",  3'b100, 0, 0, 3, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("cht3_none",      3'b111, 0, 0, 3, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("cht12_dispatch", 3'b100, 0, 0, 12, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("cht12_mni_dst",  3'b111, 0, 0, 12, NS, 0, 0, 0, O_MNI | O_DST));
        vecs.push_back(mk("data_m_disp",    3'b101, 0, 0, 12, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("data_m_enables", 3'b111, 0, 0, 12, NS, 0, 0, 0, O_QTU | O_RW | O_DST));
        vecs.push_back(mk("data_m_wait",    3'b111, 0, 0, 12, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("data_m_send",    3'b111, 0, 0, 12, NS, 1, 0, 0, O_OK));
        vecs.push_back(mk("data_ch_disp",   3'b101, 0, 0, 12, NS, 0, 1, 0, O_NONE));
        vecs.push_back(mk("data_ch_en",     3'b111, 0, 0, 12, NS, 1, 1, 0, O_QTU | O_RW | O_DST));
        vecs.push_back(mk("data_ch_nosend", 3'b111, 0, 0, 12, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("data_x_disp",    3'b101, 0, 0, 3, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("data_x_none",    3'b111, 0, 0, 3, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("data_x_nosend",  3'b111, 0, 0, 3, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("sos_dispatch",   3'b110, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("sos_enables",    3'b111, 0, 0, 0, NS, 0, 0, 0, O_KCH | O_QTU));
        vecs.push_back(mk("che_dispatch",   3'b001, 0, 0, 0, NS, 0, 0, 0, O_NONE));
        vecs.push_back(mk("che_mni",        3'b111, 0, 0, 0, NS, 1, 0, 0, O_MNI));
        vecs.push_back(mk("che_nosend",     3'b111, 0, 0, 0, NS, 1, 0, 0, O_NONE));
        vecs.push_back(mk("inv_ch_disp",    3'b010, 1, 0, 0, NS, 0, 1, 0, O_NONE));
        vecs.push_back(mk("inv_ch_kch",     3'b111, 1, 0, 0, NS, 1, 1, 0, O_KCH));
        vecs.push_back(mk("inv_ch_nosend",  3'b111, 1, 0, 0, NS, 1, 1, 0, O_NONE));
        vecs.push_back(mk("own_start",      3'b111, 0, 0, 0, 5, 0, 0, 1, O_NONE));
        vecs.push_back(mk("own_wait_ign",   3'b000, 0, 0, 0, 5, 0, 0, 0, O_NONE));
        vecs.push_back(mk("own_wait_clear", 3'b111, 0, 0, 0, 5, 1, 0, 0, O_NONE));
        vecs.push_back(mk("own_send",       3'b111, 0, 0, 0, 5, 1, 0, 0, O_OK));
        vecs.push_back(mk("own_noslot_a",   3'b111, 0, 0, 0, NS, 1, 0, 1, O_NONE));
        vecs.push_back(mk("own_noslot_b",   3'b111, 0, 0, 0, NS, 1, 0, 1, O_NONE));
        vecs.push_back(mk("own_noslot_c",   3'b111, 0, 0, 0, NS, 1, 0, 1, O_NONE));
        vecs.push_back(mk("prio_dispatch",  3'b001, 0, 0, 0, 5, 1, 0, 1, O_NONE));
        vecs.push_back(mk("prio_che_mni",   3'b111, 0, 0, 0, 5, 1, 0, 0, O_MNI));
        vecs.push_back(mk("prio_idle",      3'b111, 0, 0, 0, 5, 1, 0, 0, O_NONE));

        // Reset with no packet, then with a packet type present.
        nrst      = 1'b0;
        fTimeslot = 16'h00aa;
        myNodeID  = 16'd12;
        chosenCH  = 16'd23;
        fChosenCH = 16'd0;
        fHopsFromCH = 16'd0;
        destinationID = 16'd0;
        drive_idle(1'b0, 1'b0, NS);
        #1;
        check("reset_t0", outs(), O_NONE);
        repeat (2) @(negedge clk);
        #1;
        check("reset_held", outs(), O_NONE);
        fPacketType = 3'b000;
        @(negedge clk);
        #1;
        check("reset_pkt_ignored", outs(), O_NONE);
        fPacketType = 3'b111;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("reset_release", outs(), O_NONE);

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Reset while waiting for the channel: the pending send must be dropped.
        @(negedge clk);
        drive_idle(1'b0, 1'b1, 16'd5);
        #1;
        check("rstwait_idle", outs(), O_NONE);
        @(negedge clk);
        drive_idle(1'b0, 1'b0, 16'd5);
        #1;
        check("rstwait_waiting", outs(), O_NONE);
        nrst = 1'b0;
        #1;
        drive_idle(1'b1, 1'b0, 16'd5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rstwait_in_reset", outs(), O_NONE);
        end
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("rstwait_release", outs(), O_NONE);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("rstwait_no_send", outs(), O_NONE);
        end

        // Reset asserted mid-cycle in SEND clears okToSend without waiting for a clock.
        @(negedge clk);
        drive_idle(1'b1, 1'b1, 16'd5);
        @(negedge clk);
        drive_idle(1'b1, 1'b0, 16'd5);
        #1;
        check("rstsend_wait", outs(), O_NONE);
        @(negedge clk);
        #1;
        check("rstsend_send", outs(), O_OK);
        #1;
        nrst = 1'b0;
        #1;
        check("rstsend_async_clear", outs(), O_NONE);
        @(negedge clk);
        nrst = 1'b1;
        #1;
        check("rstsend_release", outs(), O_NONE);
        @(negedge clk);
        #1;
        check("rstsend_stays_idle", outs(), O_NONE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
